airplane_ctrl: RTL and testbench
================================

# airplane_ctrl

Control sequencer that drives the airplane `datapath` through its load and count interface. It loads the airplane position and colour, then strobes 16 pixel enables to draw the 4×4 sprite. It waits a fixed number of frames, erases the sprite with the background colour, and applies up/down moves with clamping. It sits between the key inputs and `datapath`; `datapath`'s x/y/colour outputs and this block's `plot` go to the VGA adapter.

## Interface
- `X_START`, 9'd20: fixed sprite column.
- `Y_START`, 8'd60: sprite row after reset.
- `Y_MIN`, 8'd0: topmost legal row.
- `Y_MAX`, 8'd236: bottommost legal row (240 − 4).
- `STEP`, 8'd1: rows moved per move.
- `PLANE_COLOR`, 3'b111: draw colour.
- `BG_COLOR`, 3'b000: erase colour.
- `TICK_DIV`, 833333: clk cycles per frame tick (60 Hz at 50 MHz), ≥ 2.
- `FRAMES_PER_MOVE`, 15: frame ticks spent in WAIT, 1..15.
- `clk`, in, 1: clock.
- `reset_n`, in, 1: reset; asynchronous, active-low.
- `up`, in, 1: move-up request (row decreases), active-high.
- `down`, in, 1: move-down request (row increases), active-high.
- `x_in`, out, 9: to `datapath.x_in`.
- `y_in`, out, 8: to `datapath.y_in`.
- `color_in`, out, 3: to `datapath.color_in`.
- `ld_x`, `ld_y`, `ld_color`, out, 1 each: datapath load strobes.
- `enable`, out, 1: datapath pixel-counter advance.
- `plot`, out, 1: VGA write enable.

## Operation
- States: IDLE → LOAD_DRAW → DRAW → WAIT → LOAD_ERASE → ERASE → MOVE → LOAD_DRAW …
- **IDLE** (reset state, 1 cycle): all strobes 0.
- **LOAD_DRAW** (1 cycle):
  - `ld_x` = `ld_y` = `ld_color` = 1.
  - `x_in` = `X_START`, `y_in` = `y_pos`, `color_in` = `PLANE_COLOR`.
- **DRAW**: `enable` = `plot` = 1 for exactly 16 cycles, tracked by a 4-bit pixel counter 0..15.
  - Exit to WAIT on pixel count 15.
  - The datapath x/y counters start and end at 0.
- **WAIT**: strobes 0.
  - Tick divider and frame count restart on entry.
  - Exit when the `FRAMES_PER_MOVE`-th tick occurs.
- **LOAD_ERASE**: as LOAD_DRAW, but with `color_in` = `BG_COLOR`.
- **ERASE**: as DRAW, 16 cycles.
- **MOVE** (1 cycle): strobes 0; `y_pos` updates at the exit edge.
  - `up` & !`down`: `y_pos` = max(`y_pos` − `STEP`, `Y_MIN`).
  - `down` & !`up`: `y_pos` = min(`y_pos` + `STEP`, `Y_MAX`).
  - Both or neither asserted: `y_pos` unchanged.
- Arithmetic uses 9 bits internally so subtraction below 0 and addition above 255 clamp and never wrap.
- In every state except LOAD_*, `x_in`, `y_in` and `color_in` still show `X_START`, `y_pos` and the last loaded colour.

## Timing
- Reset (asynchronous, any state, mid-DRAW included):
  - State → IDLE; `y_pos` = `Y_START`; pixel, tick and frame counters = 0.
  - All strobes 0; `color_in` = `BG_COLOR`.
- Datapath reset is synchronous, so a shared `reset_n` clears both; the first LOAD_DRAW is the cycle after reset release plus IDLE.
- Load-to-draw latency: datapath registers update at the LOAD_* exit edge; first plotted pixel is the next cycle.
- Each plotted pixel uses the datapath count present in that cycle; the counter advances at the same edge.
- WAIT lasts exactly `TICK_DIV` × `FRAMES_PER_MOVE` cycles.
- Loop period: 35 + `TICK_DIV` × `FRAMES_PER_MOVE` cycles.
- `up`/`down` are treated as synchronous; synchronising them is the top level's job.

## Configuration
- `AIRPLANE_CTRL_LATCH_EN` defined:
  - `up`/`down` are OR-latched into sticky request bits during WAIT, LOAD_ERASE, ERASE and MOVE.
  - MOVE uses the latched bits, then clears them.
  - A both-latched result means no move.
- Undefined: only the `up`/`down` levels in the MOVE cycle matter; no latch flops.

## Structure
- Shared package `airplane_pkg`:
  - state enum;
  - `SPRITE_W` = `SPRITE_H` = 4 and `SPRITE_PIXELS` = 16;
  - screen limits (320×240);
  - colour constants.
- Sub-module `frame_tick_gen`: divider with synchronous `restart`.
  - Outputs a 1-cycle `tick` every `TICK_DIV` cycles after restart.
  - Asynchronous active-low reset.

## Test plan
All scenarios use `TICK_DIV` = 4, `FRAMES_PER_MOVE` = 2, so WAIT is 8 cycles.
- **Reset release:** IDLE 1 cycle, then LOAD_DRAW with `x_in` = 20, `y_in` = 60, `color_in` = 7, `ld_*` = 1. Then `plot` is high for exactly 16 cycles, and low for exactly 8 WAIT cycles.
- **Erase:** after WAIT, `ld_*` with `color_in` = 0 at row 60, then 16 `plot` cycles. Full loop period is 43 cycles.
- **Moves:** `down` held through MOVE → next LOAD_DRAW `y_in` = 61. `up` held twice from 60 → 58. `up` and `down` together → 60.
- **Clamping:** `Y_START` = 1, `STEP` = 3, `up` → 0. `Y_START` = 235, `down` → 236, then stays 236.
- **Mid-draw reset:** assert `reset_n` = 0 mid-DRAW at pixel 7 → `plot` and `enable` drop immediately (asynchronous). After release, the sequence restarts with a full 16-pixel draw at row 60.
- **Latch macro:**
  - With `AIRPLANE_CTRL_LATCH_EN`, a 1-cycle `up` pulse during WAIT moves to 59.
  - Without it, the same pulse leaves the row at 60.

Source files
------------

// File: rtl/airplane_pkg.sv
// airplane_pkg: shared FSM states, sprite geometry, screen limits and colours for the airplane sprite.
package airplane_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_DRAW, DRAW, WAIT, LOAD_ERASE, ERASE, MOVE} state_t;
    localparam int SPRITE_W = 4;
    localparam int SPRITE_H = 4;
    localparam int SPRITE_PIXELS = SPRITE_W * SPRITE_H;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam logic [2:0] COLOR_WHITE = 3'b111;
    localparam logic [2:0] COLOR_BLACK = 3'b000;
endpackage

// File: rtl/airplane_ctrl_if.sv
// airplane_ctrl_if: load/count bus from airplane_ctrl to the datapath, plus the VGA plot strobe.
interface airplane_ctrl_if;
    logic [8:0] x_in;
    logic [7:0] y_in;
    logic [2:0] color_in;
    logic ld_x, ld_y, ld_color, enable, plot;
    modport master (output x_in, y_in, color_in, ld_x, ld_y, ld_color, enable, plot);
    modport slave (input x_in, y_in, color_in, ld_x, ld_y, ld_color, enable, plot);
endinterface

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-cycle tick every TICK_DIV cycles, held at phase zero while restart is high.
module frame_tick_gen #(
    parameter int TICK_DIV = 833333
) (
    input  logic clk,
    input  logic reset_n,
    input  logic restart,
    output logic tick
);
    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt <= '0;
        else cnt <= (restart || cnt == LAST) ? '0 : cnt + W'(1);
    assign tick = !restart && cnt == LAST;
endmodule

// File: rtl/airplane_ctrl.sv
// airplane_ctrl: draw / wait / erase / move sequencer for the 4x4 airplane sprite datapath.
// Defining AIRPLANE_CTRL_LATCH_EN latches up/down requests from WAIT through MOVE.
module airplane_ctrl
    import airplane_pkg::*;
#(
    parameter logic [8:0] X_START = 9'd20,
    parameter logic [7:0] Y_START = 8'd60,
    parameter logic [7:0] Y_MIN = 8'd0,
    parameter logic [7:0] Y_MAX = 8'(SCREEN_H - SPRITE_H),
    parameter logic [7:0] STEP = 8'd1,
    parameter logic [2:0] PLANE_COLOR = COLOR_WHITE,
    parameter logic [2:0] BG_COLOR = COLOR_BLACK,
    parameter int TICK_DIV = 833333,
    parameter int FRAMES_PER_MOVE = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic up,
    input  logic down,
    airplane_ctrl_if.master dp
);
    localparam logic [3:0] LAST_PIX = 4'(SPRITE_PIXELS - 1);
    localparam logic [3:0] LAST_FRAME = 4'(FRAMES_PER_MOVE - 1);
    state_t state, next;
    logic [7:0] y_pos, y_next;
    logic [8:0] y_sum;
    logic [3:0] pix, frame;
    logic [2:0] color;
    logic tick, move_up, move_dn, loading, drawing;

    frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk(clk),
        .reset_n(reset_n),
        .restart(state != WAIT),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= next;

    always_comb begin
        next = IDLE;
        case (state)
            IDLE:       next = LOAD_DRAW;
            LOAD_DRAW:  next = DRAW;
            DRAW:       next = pix == LAST_PIX ? WAIT : DRAW;
            WAIT:       next = (tick && frame == LAST_FRAME) ? LOAD_ERASE : WAIT;
            LOAD_ERASE: next = ERASE;
            ERASE:      next = pix == LAST_PIX ? MOVE : ERASE;
            MOVE:       next = LOAD_DRAW;
            default:    next = IDLE;
        endcase
    end

    always_comb begin
        loading = state == LOAD_DRAW || state == LOAD_ERASE;
        drawing = state == DRAW || state == ERASE;
        dp.ld_x = loading;
        dp.ld_y = loading;
        dp.ld_color = loading;
        dp.enable = drawing;
        dp.plot = drawing;
        dp.x_in = X_START;
        dp.y_in = y_pos;
        dp.color_in = state == LOAD_DRAW ? PLANE_COLOR : state == LOAD_ERASE ? BG_COLOR : color;
    end

`ifdef AIRPLANE_CTRL_LATCH_EN
    logic req_up, req_dn, latching;
    assign latching = state inside {WAIT, LOAD_ERASE, ERASE};
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) {req_up, req_dn} <= 2'b00;
        else if (state == MOVE) {req_up, req_dn} <= 2'b00;
        else if (latching) {req_up, req_dn} <= {req_up | up, req_dn | down};
    assign move_up = req_up | up;
    assign move_dn = req_dn | down;
`else
    assign move_up = up;
    assign move_dn = down;
`endif

    // 9-bit compare/sum so clamping happens before any 8-bit wrap
    always_comb begin
        y_sum = {1'b0, y_pos} + {1'b0, STEP};
        y_next = (move_up && !move_dn) ?
                     (({1'b0, y_pos} < {1'b0, Y_MIN} + {1'b0, STEP}) ? Y_MIN : y_pos - STEP) :
                 (move_dn && !move_up) ?
                     ((y_sum > {1'b0, Y_MAX}) ? Y_MAX : y_sum[7:0]) :
                 y_pos;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            y_pos <= Y_START;
            pix <= '0;
            frame <= '0;
            color <= BG_COLOR;
        end else begin
            pix <= drawing ? pix + 4'd1 : '0;
            frame <= state != WAIT ? '0 : frame + 4'(tick);
            if (loading) color <= state == LOAD_DRAW ? PLANE_COLOR : BG_COLOR;
            if (state == MOVE) y_pos <= y_next;
        end
endmodule

// File: tb/tb_airplane_ctrl.sv
// tb_airplane_ctrl: scoreboard and move-table checks of airplane_ctrl with TICK_DIV=4, FRAMES_PER_MOVE=2.
// The WAIT-pulse expectation follows AIRPLANE_CTRL_LATCH_EN.
module tb_airplane_ctrl;
    import airplane_pkg::*;
    typedef struct { logic u; logic d; int y; } vec_t;
    typedef struct { int y; int c; } ld_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0, up = 1'b0, down = 1'b0;
    logic rst_lo = 1'b0, up_lo = 1'b0, rst_hi = 1'b0, dn_hi = 1'b0;
    int tests = 0, fails = 0, cyc = 0;
    ld_t sb_q[$];
    ld_t sb_e;
    vec_t vecs[6];

    airplane_ctrl_if bus();
    airplane_ctrl_if bus_lo();
    airplane_ctrl_if bus_hi();

    airplane_ctrl #(.TICK_DIV(4), .FRAMES_PER_MOVE(2)) dut (
        .clk(clk), .reset_n(reset_n), .up(up), .down(down), .dp(bus)
    );
    airplane_ctrl #(.Y_START(8'd1), .STEP(8'd3), .TICK_DIV(4), .FRAMES_PER_MOVE(2)) dut_lo (
        .clk(clk), .reset_n(rst_lo), .up(up_lo), .down(1'b0), .dp(bus_lo)
    );
    airplane_ctrl #(.Y_START(8'd235), .TICK_DIV(4), .FRAMES_PER_MOVE(2)) dut_hi (
        .clk(clk), .reset_n(rst_hi), .up(1'b0), .down(dn_hi), .dp(bus_hi)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_draw(input int k, output int y);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(k == 0 ? (bus.ld_x && bus.color_in == 3'd7) :
                     k == 1 ? (bus_lo.ld_x && bus_lo.color_in == 3'd7) :
                              (bus_hi.ld_x && bus_hi.color_in == 3'd7)) && n < 200);
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL wait_draw[%0d]: no LOAD_DRAW within %0d cycles", k, n);
        end
        y = k == 0 ? int'(bus.y_in) : k == 1 ? int'(bus_lo.y_in) : int'(bus_hi.y_in);
    endtask

    // scoreboard: every load cycle of the main DUT pops one expected {row, colour}
    always begin
        @(posedge clk);
        #1;
        if (reset_n && bus.ld_x) begin
            check("ld_strobes", {bus.ld_x, bus.ld_y, bus.ld_color}, 7);
            check("ld_x_in", bus.x_in, 20);
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: load at y=%0d color=%0d, nothing expected", bus.y_in, bus.color_in);
            end else begin
                sb_e = sb_q.pop_front();
                check("ld_y_in", bus.y_in, sb_e.y);
                check("ld_color_in", bus.color_in, sb_e.c);
            end
        end
    end

    initial begin
        int n, t0, y;
        vecs[0] = '{1'b0, 1'b1, 61};
        vecs[1] = '{1'b1, 1'b0, 60};
        vecs[2] = '{1'b1, 1'b1, 60};
        vecs[3] = '{1'b1, 1'b0, 59};
        vecs[4] = '{1'b1, 1'b0, 58};
        vecs[5] = '{1'b0, 1'b0, 58};

        repeat (3) step();
        check("rst_plot", bus.plot, 0);
        check("rst_enable", bus.enable, 0);
        check("rst_ld", bus.ld_x, 0);
        check("rst_color", bus.color_in, 0);
        check("rst_y", bus.y_in, 60);
        check("rst_x", bus.x_in, 20);

        sb_q.push_back('{60, 7});
        reset_n = 1'b1;
        check("idle_ld", bus.ld_x, 0);
        step();
        check("first_ld", bus.ld_x, 1);
        t0 = cyc;
        sb_q.push_back('{60, 0});
        sb_q.push_back('{60, 7});
        n = 0;
        step();
        while (bus.plot && n < 40) begin n++; step(); end
        check("draw_len", n, 16);
        n = 0;
        while (!bus.ld_x && !bus.plot && n < 40) begin n++; step(); end
        check("wait_len", n, 8);
        check("erase_ld", bus.ld_x, 1);
        n = 0;
        step();
        while (bus.plot && n < 40) begin n++; step(); end
        check("erase_len", n, 16);
        check("move_quiet", bus.plot | bus.ld_x, 0);
        step();
        check("loop_ld", bus.ld_x, 1);
        check("loop_period", cyc - t0, 43);

        y = 60;
        foreach (vecs[i]) begin
            up = vecs[i].u;
            down = vecs[i].d;
            sb_q.push_back('{y, 0});
            sb_q.push_back('{vecs[i].y, 7});
            wait_draw(0, y);
            up = 1'b0;
            down = 1'b0;
            check("move_y", y, vecs[i].y);
        end

        repeat (8) step();
        check("mid_plot", bus.plot, 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_plot", bus.plot, 0);
        check("async_enable", bus.enable, 0);
        check("async_y", bus.y_in, 60);
        sb_q.delete();
        sb_q.push_back('{60, 7});
        sb_q.push_back('{60, 0});
`ifdef AIRPLANE_CTRL_LATCH_EN
        sb_q.push_back('{59, 7});
`else
        sb_q.push_back('{60, 7});
`endif
        step();
        step();
        reset_n = 1'b1;
        check("restart_idle", bus.ld_x, 0);
        step();
        check("restart_ld", bus.ld_x, 1);
        n = 0;
        step();
        while (bus.plot && n < 40) begin n++; step(); end
        check("restart_len", n, 16);
        up = 1'b1;
        step();
        up = 1'b0;
        wait_draw(0, y);
`ifdef AIRPLANE_CTRL_LATCH_EN
        check("latch_y", y, 59);
`else
        check("latch_y", y, 60);
`endif
        reset_n = 1'b0;

        rst_lo = 1'b1;
        wait_draw(1, y);
        check("lo_start", y, 1);
        up_lo = 1'b1;
        wait_draw(1, y);
        check("lo_clamp", y, 0);
        wait_draw(1, y);
        check("lo_stay", y, 0);

        rst_hi = 1'b1;
        wait_draw(2, y);
        check("hi_start", y, 235);
        dn_hi = 1'b1;
        wait_draw(2, y);
        check("hi_clamp", y, 236);
        wait_draw(2, y);
        check("hi_stay", y, 236);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
